lcrc_seq_ctrl: RTL and testbench

LCRC_SEQ_CTRL -- requirements
Module: lcrc_seq_ctrl

---
 rtl/lcrc_pkg.sv | 21 ++
 rtl/lcrc_req_arb.sv | 41 ++++
 rtl/lcrc_seq_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_lcrc_seq_ctrl.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcrc_pkg.sv
// Shared types and constants for the LCRC sequence controller.
package lcrc_pkg;

  localparam int unsigned SEQ_W_DEF  = 12;
  localparam int unsigned BEAT_W_DEF = 128;

  localparam logic [1:0] CTRL_SEQ  = 2'b00;
  localparam logic [1:0] CTRL_HI   = 2'b01;
  localparam logic [1:0] CTRL_LO   = 2'b10;
  localparam logic [1:0] CTRL_CALC = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StSeq,
    StTlpHi,
    StTlpLo,
    StCalc,
    StHold
  } state_e;

endpackage

// File: rtl/lcrc_req_arb.sv
// Two-requester grant logic: strict replay priority, or round-robin when LCRC_ARB_RR_EN is defined.
module lcrc_req_arb (
`ifdef LCRC_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic accept,
`endif
  input  logic new_valid,
  input  logic rpl_valid,
  output logic gnt_new,
  output logic gnt_rpl
);

`ifdef LCRC_ARB_RR_EN
  // Set when replay won the last accepted grant; reset favours replay.
  logic last_rpl_q, last_rpl_d;

  always_comb begin
    gnt_rpl    = rpl_valid && (!new_valid || !last_rpl_q);
    gnt_new    = new_valid && !gnt_rpl;
    last_rpl_d = last_rpl_q;
    if (accept) begin
      last_rpl_d = gnt_rpl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_rpl_q <= 1'b0;
    end else begin
      last_rpl_q <= last_rpl_d;
    end
  end
`else
  always_comb begin
    gnt_rpl = rpl_valid;
    gnt_new = new_valid && !rpl_valid;
  end
`endif

endmodule

// File: rtl/lcrc_seq_ctrl.sv
// Sequences fresh/replay TLPs through an external LCRC engine and presents the result.
// Define LCRC_ARB_RR_EN for round-robin arbitration between the two requesters.
module lcrc_seq_ctrl
  import lcrc_pkg::*;
#(
  parameter int unsigned SEQ_W  = SEQ_W_DEF,
  parameter int unsigned BEAT_W = BEAT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  new_valid,
  output logic                  new_ready,
  input  logic [SEQ_W-1:0]      new_seq,
  input  logic [2*BEAT_W-1:0]   new_data,
  input  logic                  new_len256,

  input  logic                  rpl_valid,
  output logic                  rpl_ready,
  input  logic [SEQ_W-1:0]      rpl_seq,
  input  logic [2*BEAT_W-1:0]   rpl_data,
  input  logic                  rpl_len256,

  output logic [1:0]            lcrc_ctrl,
  output logic                  lcrc_start,
  output logic [BEAT_W-1:0]     lcrc_data,
  output logic                  lcrc_tlp_end,
  output logic                  lcrc_skip_256,

  input  logic [31:0]           lcrc_in,
  input  logic                  lcrc_in_valid,

  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_lcrc,
  output logic [SEQ_W-1:0]      out_seq,
  output logic                  out_src,

  output logic                  busy
);

  state_e                state_q, state_d;
  logic [SEQ_W-1:0]      seq_q, seq_d;
  logic [2*BEAT_W-1:0]   data_q, data_d;
  logic                  len256_q, len256_d;
  logic                  src_q, src_d;
  logic [31:0]           out_lcrc_q, out_lcrc_d;

  logic [1:0]            ctrl_q, ctrl_d;
  logic                  start_q, start_d;
  logic [BEAT_W-1:0]     ldata_q, ldata_d;
  logic                  tlp_end_q, tlp_end_d;
  logic                  skip_q, skip_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;

  logic                  gnt_new, gnt_rpl;
  logic                  idle;

  assign idle = (state_q == StIdle);

`ifdef LCRC_ARB_RR_EN
  logic arb_accept;
  assign arb_accept = idle && !rst && (new_valid || rpl_valid);
`endif

  lcrc_req_arb u_arb (
`ifdef LCRC_ARB_RR_EN
    .clk       (clk),
    .rst       (rst),
    .accept    (arb_accept),
`endif
    .new_valid (new_valid),
    .rpl_valid (rpl_valid),
    .gnt_new   (gnt_new),
    .gnt_rpl   (gnt_rpl)
  );

  // Ready is combinational so the handshake completes in the IDLE cycle itself.
  assign new_ready = idle && !rst && gnt_new;
  assign rpl_ready = idle && !rst && gnt_rpl;

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    data_d     = data_q;
    len256_d   = len256_q;
    src_d      = src_q;
    out_lcrc_d = out_lcrc_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_rpl) begin
          seq_d    = rpl_seq;
          data_d   = rpl_data;
          len256_d = rpl_len256;
          src_d    = 1'b1;
          state_d  = StSeq;
        end else if (gnt_new) begin
          seq_d    = new_seq;
          data_d   = new_data;
          len256_d = new_len256;
          src_d    = 1'b0;
          state_d  = StSeq;
        end
      end
      StSeq:   state_d = StTlpHi;
      StTlpHi: state_d = len256_q ? StTlpLo : StCalc;
      StTlpLo: state_d = StCalc;
      StCalc: begin
        if (lcrc_in_valid) begin
          out_lcrc_d = lcrc_in;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Engine command and status outputs are registered, decoded from the next state.
  always_comb begin
    ctrl_d      = CTRL_SEQ;
    start_d     = 1'b0;
    ldata_d     = '0;
    tlp_end_d   = 1'b0;
    skip_d      = 1'b0;
    out_valid_d = (state_d == StHold);
    busy_d      = (state_d != StIdle);
    unique case (state_d)
      StSeq: begin
        start_d = 1'b1;
        ldata_d = {{(BEAT_W-SEQ_W){1'b0}}, seq_d};
      end
      StTlpHi: begin
        ctrl_d    = CTRL_HI;
        ldata_d   = data_d[2*BEAT_W-1:BEAT_W];
        tlp_end_d = !len256_d;
      end
      StTlpLo: begin
        ctrl_d  = CTRL_LO;
        ldata_d = data_d[BEAT_W-1:0];
      end
      StCalc: begin
        ctrl_d = CTRL_CALC;
        skip_d = !len256_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      seq_q       <= '0;
      data_q      <= '0;
      len256_q    <= 1'b0;
      src_q       <= 1'b0;
      out_lcrc_q  <= '0;
      ctrl_q      <= CTRL_SEQ;
      start_q     <= 1'b0;
      ldata_q     <= '0;
      tlp_end_q   <= 1'b0;
      skip_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      data_q      <= data_d;
      len256_q    <= len256_d;
      src_q       <= src_d;
      out_lcrc_q  <= out_lcrc_d;
      ctrl_q      <= ctrl_d;
      start_q     <= start_d;
      ldata_q     <= ldata_d;
      tlp_end_q   <= tlp_end_d;
      skip_q      <= skip_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign lcrc_ctrl     = ctrl_q;
  assign lcrc_start    = start_q;
  assign lcrc_data     = ldata_q;
  assign lcrc_tlp_end  = tlp_end_q;
  assign lcrc_skip_256 = skip_q;
  assign out_valid     = out_valid_q;
  assign out_lcrc      = out_lcrc_q;
  assign out_seq       = seq_q;
  assign out_src       = src_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_lcrc_seq_ctrl.sv
// Directed self-checking bench for lcrc_seq_ctrl with a combinational LCRC engine model.
module tb_lcrc_seq_ctrl;

  localparam int SW = 12;
  localparam int BW = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic            new_valid, new_ready, new_len256;
  logic [SW-1:0]   new_seq;
  logic [2*BW-1:0] new_data;
  logic            rpl_valid, rpl_ready, rpl_len256;
  logic [SW-1:0]   rpl_seq;
  logic [2*BW-1:0] rpl_data;
  logic [1:0]      lcrc_ctrl;
  logic            lcrc_start, lcrc_tlp_end, lcrc_skip_256;
  logic [BW-1:0]   lcrc_data;
  logic [31:0]     lcrc_in;
  logic            lcrc_in_valid;
  logic            out_valid, out_ready, out_src, busy;
  logic [31:0]     out_lcrc;
  logic [SW-1:0]   out_seq;

  logic            eng_en;
  logic [31:0]     eng_crc;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  assign lcrc_in       = eng_crc;
  assign lcrc_in_valid = eng_en && (lcrc_ctrl == 2'b11);

  lcrc_seq_ctrl #(.SEQ_W(SW), .BEAT_W(BW)) dut (
    .clk           (clk),
    .rst           (rst),
    .new_valid     (new_valid),
    .new_ready     (new_ready),
    .new_seq       (new_seq),
    .new_data      (new_data),
    .new_len256    (new_len256),
    .rpl_valid     (rpl_valid),
    .rpl_ready     (rpl_ready),
    .rpl_seq       (rpl_seq),
    .rpl_data      (rpl_data),
    .rpl_len256    (rpl_len256),
    .lcrc_ctrl     (lcrc_ctrl),
    .lcrc_start    (lcrc_start),
    .lcrc_data     (lcrc_data),
    .lcrc_tlp_end  (lcrc_tlp_end),
    .lcrc_skip_256 (lcrc_skip_256),
    .lcrc_in       (lcrc_in),
    .lcrc_in_valid (lcrc_in_valid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_lcrc      (out_lcrc),
    .out_seq       (out_seq),
    .out_src       (out_src),
    .busy          (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hold(input int bound, output int n);
    n = 0;
    while (!out_valid && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic release_hold();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    new_valid = 1'b1;
    rpl_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (new_ready !== 1'b0 || rpl_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: new_ready=%b rpl_ready=%b, want 0 0", new_ready, rpl_ready);
    end
    rst = 1'b0;
    new_valid = 1'b0;
    rpl_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || lcrc_ctrl !== 2'b00 || lcrc_start !== 1'b0
        || lcrc_data !== '0 || lcrc_tlp_end !== 1'b0 || lcrc_skip_256 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b ov=%b ctrl=%b start=%b data=%h end=%b skip=%b, want 0",
               busy, out_valid, lcrc_ctrl, lcrc_start, lcrc_data, lcrc_tlp_end, lcrc_skip_256);
    end
    checks++;
    if (out_lcrc !== 32'h0 || out_seq !== '0 || out_src !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: lcrc=%h seq=%h src=%b, want 0", out_lcrc, out_seq, out_src);
    end
  endtask

  task automatic test_new_128();
    eng_en = 1'b1;
    eng_crc = 32'hDEADBEEF;
    new_seq = 12'h005;
    new_data = {128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0};
    new_len256 = 1'b0;
    new_valid = 1'b1;
    #1;
    checks++;
    if (new_ready !== 1'b1 || rpl_ready !== 1'b0) begin
      errors++;
      $display("FAIL new128_ready: new_ready=%b rpl_ready=%b, want 1 0", new_ready, rpl_ready);
    end
    tick();
    new_valid = 1'b0;
    checks++;
    if (lcrc_ctrl !== 2'b00 || lcrc_start !== 1'b1 || lcrc_data !== 128'h005 || busy !== 1'b1) begin
      errors++;
      $display("FAIL new128_seq: ctrl=%b start=%b data=%h busy=%b, want 00 1 005 1",
               lcrc_ctrl, lcrc_start, lcrc_data, busy);
    end
    tick();
    checks++;
    if (lcrc_ctrl !== 2'b01 || lcrc_tlp_end !== 1'b1 || lcrc_start !== 1'b0
        || lcrc_data !== 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677) begin
      errors++;
      $display("FAIL new128_hi: ctrl=%b end=%b start=%b data=%h, want 01 1 0 hi-beat",
               lcrc_ctrl, lcrc_tlp_end, lcrc_start, lcrc_data);
    end
    tick();
    checks++;
    if (lcrc_ctrl !== 2'b11 || lcrc_skip_256 !== 1'b1 || lcrc_tlp_end !== 1'b0
        || lcrc_data !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL new128_calc: ctrl=%b skip=%b end=%b data=%h ov=%b, want 11 1 0 0 0",
               lcrc_ctrl, lcrc_skip_256, lcrc_tlp_end, lcrc_data, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_lcrc !== 32'hDEADBEEF || out_seq !== 12'h005
        || out_src !== 1'b0 || lcrc_ctrl !== 2'b00 || lcrc_skip_256 !== 1'b0) begin
      errors++;
      $display("FAIL new128_hold: ov=%b lcrc=%h seq=%h src=%b ctrl=%b skip=%b, want 1 DEADBEEF 005 0 00 0",
               out_valid, out_lcrc, out_seq, out_src, lcrc_ctrl, lcrc_skip_256);
    end
    release_hold();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL new128_done: ov=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_rpl_256();
    eng_crc = 32'h1234_5678;
    rpl_seq = 12'hFFF;
    rpl_data = {128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1111, 128'h2222_3333_4444_5555_6666_7777_8888_9999};
    rpl_len256 = 1'b1;
    rpl_valid = 1'b1;
    #1;
    checks++;
    if (rpl_ready !== 1'b1 || new_ready !== 1'b0) begin
      errors++;
      $display("FAIL rpl256_ready: rpl_ready=%b new_ready=%b, want 1 0", rpl_ready, new_ready);
    end
    tick();
    rpl_valid = 1'b0;
    checks++;
    if (lcrc_ctrl !== 2'b00 || lcrc_start !== 1'b1 || lcrc_data !== 128'hFFF) begin
      errors++;
      $display("FAIL rpl256_seq: ctrl=%b start=%b data=%h, want 00 1 FFF", lcrc_ctrl, lcrc_start, lcrc_data);
    end
    tick();
    checks++;
    if (lcrc_ctrl !== 2'b01 || lcrc_tlp_end !== 1'b0
        || lcrc_data !== 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1111) begin
      errors++;
      $display("FAIL rpl256_hi: ctrl=%b end=%b data=%h, want 01 0 hi-beat", lcrc_ctrl, lcrc_tlp_end, lcrc_data);
    end
    tick();
    checks++;
    if (lcrc_ctrl !== 2'b10 || lcrc_data !== 128'h2222_3333_4444_5555_6666_7777_8888_9999) begin
      errors++;
      $display("FAIL rpl256_lo: ctrl=%b data=%h, want 10 lo-beat", lcrc_ctrl, lcrc_data);
    end
    tick();
    checks++;
    if (lcrc_ctrl !== 2'b11 || lcrc_skip_256 !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rpl256_calc: ctrl=%b skip=%b ov=%b, want 11 0 0", lcrc_ctrl, lcrc_skip_256, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b1 || out_seq !== 12'hFFF || out_lcrc !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rpl256_hold: ov=%b src=%b seq=%h lcrc=%h, want 1 1 FFF 12345678",
               out_valid, out_src, out_seq, out_lcrc);
    end
    release_hold();
  endtask

  task automatic test_arb_priority();
    int n;
    eng_crc = 32'h0BAD_F00D;
    new_seq = 12'h010;
    new_len256 = 1'b0;
    rpl_seq = 12'h020;
    rpl_len256 = 1'b0;
    new_valid = 1'b1;
    rpl_valid = 1'b1;
    #1;
    checks++;
    if (rpl_ready !== 1'b1 || new_ready !== 1'b0) begin
      errors++;
      $display("FAIL arb_first: rpl_ready=%b new_ready=%b, want 1 0", rpl_ready, new_ready);
    end
    tick();
    rpl_valid = 1'b0;
    wait_hold(20, n);
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b1 || out_seq !== 12'h020) begin
      errors++;
      $display("FAIL arb_first_out: ov=%b src=%b seq=%h, want 1 1 020", out_valid, out_src, out_seq);
    end
    release_hold();
    checks++;
    if (new_ready !== 1'b1 || rpl_ready !== 1'b0) begin
      errors++;
      $display("FAIL arb_second: new_ready=%b rpl_ready=%b, want 1 0", new_ready, rpl_ready);
    end
    tick();
    new_valid = 1'b0;
    wait_hold(20, n);
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b0 || out_seq !== 12'h010) begin
      errors++;
      $display("FAIL arb_second_out: ov=%b src=%b seq=%h, want 1 0 010", out_valid, out_src, out_seq);
    end
    release_hold();
  endtask

  task automatic test_back_to_back();
    int n;
    logic exp_rpl;
    logic [SW-1:0] exp_seq;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    eng_crc = 32'h5555_AAAA;
    new_seq = 12'h100;
    rpl_seq = 12'h200;
    new_len256 = 1'b0;
    rpl_len256 = 1'b0;
    new_valid = 1'b1;
    rpl_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!new_ready && !rpl_ready && n < 20) begin
        tick();
        n++;
      end
`ifdef LCRC_ARB_RR_EN
      exp_rpl = (g % 2 == 0);
`else
      exp_rpl = 1'b1;
`endif
      exp_seq = exp_rpl ? rpl_seq : new_seq;
      checks++;
      if (rpl_ready !== exp_rpl || new_ready !== !exp_rpl) begin
        errors++;
        $display("FAIL b2b_grant%0d: rpl_ready=%b new_ready=%b, want %b %b",
                 g, rpl_ready, new_ready, exp_rpl, !exp_rpl);
      end
      tick();
      if (exp_rpl) rpl_seq = rpl_seq + 12'h1;
      else new_seq = new_seq + 12'h1;
      wait_hold(20, n);
      checks++;
      if (out_valid !== 1'b1 || out_src !== exp_rpl || out_seq !== exp_seq) begin
        errors++;
        $display("FAIL b2b_out%0d: ov=%b src=%b seq=%h, want 1 %b %h",
                 g, out_valid, out_src, out_seq, exp_rpl, exp_seq);
      end
      tick();
    end
    new_valid = 1'b0;
    rpl_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_hold_stall();
    int n;
    logic ok;
    eng_crc = 32'hC0DE_1234;
    new_seq = 12'h0AB;
    new_len256 = 1'b0;
    new_valid = 1'b1;
    #1;
    tick();
    new_valid = 1'b0;
    wait_hold(20, n);
    new_valid = 1'b1;
    rpl_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid !== 1'b1 || out_lcrc !== 32'hC0DE_1234 || out_seq !== 12'h0AB
          || new_ready !== 1'b0 || rpl_ready !== 1'b0 || busy !== 1'b1) begin
        ok = 1'b0;
        $display("FAIL stall_cycle%0d: ov=%b lcrc=%h seq=%h nr=%b rr=%b busy=%b, want 1 C0DE1234 0AB 0 0 1",
                 i, out_valid, out_lcrc, out_seq, new_ready, rpl_ready, busy);
      end
      tick();
    end
    checks++;
    if (!ok) errors++;
    out_ready = 1'b1;
    #1;
    checks++;
    if (new_ready !== 1'b0 || rpl_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_release_ready: nr=%b rr=%b, want 0 0", new_ready, rpl_ready);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || rpl_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_idle: busy=%b ov=%b rr=%b, want 0 0 1", busy, out_valid, rpl_ready);
    end
    new_valid = 1'b0;
    rpl_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    eng_crc = 32'h7777_8888;
    rpl_seq = 12'h3C3;
    rpl_data = {8{32'hA5A5_5A5A}};
    rpl_len256 = 1'b1;
    rpl_valid = 1'b1;
    #1;
    tick();
    rpl_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (lcrc_ctrl !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_lo: ctrl=%b, want 10", lcrc_ctrl);
    end
    rst = 1'b1;
    new_seq = 12'h007;
    new_valid = 1'b1;
    #1;
    checks++;
    if (new_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready: new_ready=%b, want 0", new_ready);
    end
    tick();
    rst = 1'b0;
    new_valid = 1'b0;
    checks++;
    if (lcrc_ctrl !== 2'b00 || busy !== 1'b0 || out_seq !== '0 || out_src !== 1'b0 || lcrc_data !== '0) begin
      errors++;
      $display("FAIL rstmid_idle: ctrl=%b busy=%b seq=%h src=%b data=%h, want 00 0 0 0 0",
               lcrc_ctrl, busy, out_seq, out_src, lcrc_data);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rstmid_no_out: out_valid seen=1, want 0");
    end
    eng_crc = 32'hCAFE_F00D;
    new_seq = 12'h055;
    new_len256 = 1'b0;
    new_valid = 1'b1;
    #1;
    tick();
    new_valid = 1'b0;
    wait_hold(20, n);
    checks++;
    if (n != 3 || out_valid !== 1'b1 || out_lcrc !== 32'hCAFE_F00D || out_seq !== 12'h055) begin
      errors++;
      $display("FAIL rstmid_next: wait=%0d ov=%b lcrc=%h seq=%h, want 3 1 CAFEF00D 055",
               n, out_valid, out_lcrc, out_seq);
    end
    release_hold();
  endtask

  task automatic test_calc_wait();
    logic ok;
    eng_en = 1'b0;
    eng_crc = 32'h1357_9BDF;
    new_seq = 12'h123;
    new_len256 = 1'b0;
    new_valid = 1'b1;
    #1;
    tick();
    new_valid = 1'b0;
    tick();
    tick();
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (lcrc_ctrl !== 2'b11 || out_valid !== 1'b0) begin
        ok = 1'b0;
        $display("FAIL calcwait_cycle%0d: ctrl=%b ov=%b, want 11 0", i, lcrc_ctrl, out_valid);
      end
      tick();
    end
    checks++;
    if (!ok) errors++;
    eng_en = 1'b1;
    #1;
    checks++;
    if (lcrc_ctrl !== 2'b11 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL calcwait_release: ctrl=%b ov=%b, want 11 0", lcrc_ctrl, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_lcrc !== 32'h1357_9BDF || out_seq !== 12'h123) begin
      errors++;
      $display("FAIL calcwait_out: ov=%b lcrc=%h seq=%h, want 1 13579BDF 123", out_valid, out_lcrc, out_seq);
    end
    release_hold();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    new_valid = 1'b0;
    new_seq = '0;
    new_data = '0;
    new_len256 = 1'b0;
    rpl_valid = 1'b0;
    rpl_seq = '0;
    rpl_data = '0;
    rpl_len256 = 1'b0;
    out_ready = 1'b0;
    eng_en = 1'b1;
    eng_crc = '0;
    #2;
    test_reset();
    test_new_128();
    test_rpl_256();
    test_arb_priority();
    test_back_to_back();
    test_hold_stall();
    test_reset_mid();
    test_calc_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
